// File: rtl/audio_frame_streamer.sv
// Snapshots one frame from the per-channel FIFO bank and serialises its enabled channels onto a valid/ready stream.
// Latency: capture edge k, adv_read_req high for cycle k..k+1, first beat valid after edge k+1, then 1 beat/cycle.
// Backpressure: m_tready low freezes the presented beat; no new frame is captured until streaming and hold-off finish.
module audio_frame_streamer #(
    parameter int AUDIO_WIDTH  = 24,
    parameter int NUM_CHANNELS = 16,
    parameter int HOLDOFF      = 3
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic [AUDIO_WIDTH-1:0]          audio_channel_in [NUM_CHANNELS],
    input  logic                            buffer_ready,
    input  logic                            buffer_full,
    input  logic [NUM_CHANNELS-1:0]         channel_enable,
    output logic                            adv_read_req,
    output logic [AUDIO_WIDTH-1:0]          m_tdata,
    output logic [$clog2(NUM_CHANNELS)-1:0] m_tchan,
    output logic                            m_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            busy,
    output logic [15:0]                     frame_count,
    output logic [15:0]                     overflow_count
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam logic [NUM_CHANNELS-1:0] BIT0 = NUM_CHANNELS'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACK    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [3:0]              hold_q, hold_d;
    logic [NUM_CHANNELS-1:0] rem_q, rem_d;
    logic [AUDIO_WIDTH-1:0]  shadow_q [NUM_CHANNELS];
    logic                    capture;
    logic                    adv_q, adv_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [AUDIO_WIDTH-1:0]  tdata_q, tdata_d;
    logic [CW-1:0]           tchan_q, tchan_d;
    logic                    busy_q;
    logic [15:0]             frame_q, frame_d;
    logic [15:0]             ovf_q, ovf_d;
    logic                    bfull_q;

    // rem_q holds the channels of the captured frame not yet presented;
    // the lowest set bit is always the next beat, and clearing it tells whether that beat is last
    logic [CW-1:0]           pick_idx;
    logic                    pick_any;
    logic [NUM_CHANNELS-1:0] pick_rest;

    // Lowest remaining enabled channel of the shadow frame
    always_comb begin
        pick_idx = '0;
        pick_any = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                pick_idx = CW'(i);
                pick_any = 1'b1;
            end
        end
        pick_rest = rem_q & ~(BIT0 << pick_idx);
    end

    // Next-state logic for the frame FSM, stream register and counters
    always_comb begin
        state_d  = state_q;
        hold_d   = (hold_q != 4'd0) ? hold_q - 4'd1 : 4'd0;
        rem_d    = rem_q;
        capture  = 1'b0;
        adv_d    = 1'b0;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tchan_d  = tchan_q;
        frame_d  = frame_q;
        ovf_d    = (buffer_full && !bfull_q && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (buffer_ready && hold_q == 4'd0) begin
                    capture = 1'b1;
                    rem_d   = channel_enable;
                    adv_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                hold_d  = 4'(HOLDOFF);
                frame_d = frame_q + 16'd1;
                if (pick_any) begin
                    tvalid_d = 1'b1;
                    tchan_d  = pick_idx;
                    tdata_d  = shadow_q[pick_idx];
                    tlast_d  = (pick_rest == '0);
                    rem_d    = pick_rest;
                    state_d  = ST_STREAM;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_STREAM: begin
                if (tvalid_q && m_tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = ST_GAP;
                    end else begin
                        tchan_d = pick_idx;
                        tdata_d = shadow_q[pick_idx];
                        tlast_d = (pick_rest == '0);
                        rem_d   = pick_rest;
                    end
                end
            end
            default: begin
                // Leave as soon as the counter reaches zero, so the next capture
                // lands exactly when the hold-off has drained
                if (hold_d == 4'd0) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Control, stream and counter registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= 4'd0;
            rem_q    <= '0;
            adv_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tchan_q  <= '0;
            busy_q   <= 1'b0;
            frame_q  <= 16'd0;
            ovf_q    <= 16'd0;
            bfull_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rem_q    <= rem_d;
            adv_q    <= adv_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tchan_q  <= tchan_d;
            busy_q   <= (state_d != ST_IDLE);
            frame_q  <= frame_d;
            ovf_q    <= ovf_d;
            bfull_q  <= buffer_full;
        end
    end

    // Shadow frame: written only at capture, so later input changes cannot leak into the stream
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (capture) begin
            shadow_q <= audio_channel_in;
        end
    end

    assign adv_read_req   = adv_q;
    assign m_tvalid       = tvalid_q;
    assign m_tlast        = tlast_q;
    assign m_tdata        = tdata_q;
    assign m_tchan        = tchan_q;
    assign busy           = busy_q;
    assign frame_count    = frame_q;
    assign overflow_count = ovf_q;

endmodule
